// File: rtl/rpn_sequencer_if.sv
// rpn_sequencer_if: ASCII byte input, RPN-core strobes and result/error outputs
// of the RPN sequencer, grouped so the core side and the byte side travel together.
interface rpn_sequencer_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        num_en;
   logic [15:0] num;
   logic        op_en;
   logic [3:0]  op;
   logic        res_ready;
   logic [15:0] res_value;
   logic        result_valid;
   logic [15:0] result;
   logic        err;
   modport master (
      output rx_valid, rx_data, res_ready, res_value,
      input  rx_ready, num_en, num, op_en, op, result_valid, result, err
   );
   modport slave (
      input  rx_valid, rx_data, res_ready, res_value,
      output rx_ready, num_en, num, op_en, op, result_valid, result, err
   );
endinterface

// File: rtl/rpn_sequencer.sv
// rpn_sequencer: parses an ASCII RPN byte stream into push/operator strobes for an
// RPN core and captures the core's answer to '=' with a bounded wait.
module rpn_sequencer #(
   parameter int OP_GAP      = 4,
   parameter int RES_TIMEOUT = 16
) (
   input logic            clk,
   input logic            rst_n,
   rpn_sequencer_if.slave bus
);
   localparam int CW = $clog2((RES_TIMEOUT > OP_GAP ? RES_TIMEOUT : OP_GAP) + 1);
   typedef enum logic [2:0] {IDLE, ACC, EMIT_NUM, EMIT_OP, GAP, WAIT_RES} state_t;
   state_t state, state_n;
   logic [15:0] acc, acc_n, res_q, res_n;
   logic [3:0] opc, opc_n, code;
   logic pend, pend_n, err_q, err_n, rv_q, rv_n;
   logic [CW-1:0] cnt, cnt_n;
   logic take, is_dig, is_term, is_op;
   logic [15:0] dig;
   assign take    = bus.rx_valid && bus.rx_ready;
   assign is_dig  = bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39;
   assign is_term = bus.rx_data == 8'h20 || bus.rx_data == 8'h0D || bus.rx_data == 8'h0A;
   assign is_op   = bus.rx_data == 8'h2B || bus.rx_data == 8'h2D || bus.rx_data == 8'h2A ||
                    bus.rx_data == 8'h2F || bus.rx_data == 8'h3D;
   assign code    = bus.rx_data == 8'h2B ? 4'd0 :
                    bus.rx_data == 8'h2D ? 4'd1 :
                    bus.rx_data == 8'h2A ? 4'd2 :
                    bus.rx_data == 8'h2F ? 4'd3 : 4'd15;
   assign dig     = {12'd0, bus.rx_data[3:0]};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         opc   <= '0;
         pend  <= 1'b0;
         cnt   <= '0;
         err_q <= 1'b0;
         rv_q  <= 1'b0;
         res_q <= '0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         opc   <= opc_n;
         pend  <= pend_n;
         cnt   <= cnt_n;
         err_q <= err_n;
         rv_q  <= rv_n;
         res_q <= res_n;
      end
   end
   always_comb begin
      state_n = state;
      acc_n   = acc;
      opc_n   = opc;
      pend_n  = pend;
      cnt_n   = cnt;
      err_n   = 1'b0;
      rv_n    = 1'b0;
      res_n   = res_q;
      case (state)
         IDLE, ACC: if (take) begin
            if (is_dig) begin
               acc_n   = state == ACC ? acc * 16'd10 + dig : dig;
               state_n = ACC;
            end else if (is_term) begin
               state_n = state == ACC ? EMIT_NUM : IDLE;
            end else if (is_op) begin
               // an operator ending a number is held until the number has been pushed
               opc_n   = code;
               pend_n  = state == ACC;
               state_n = state == ACC ? EMIT_NUM : EMIT_OP;
            end else begin
               err_n   = 1'b1;
               acc_n   = '0;
               opc_n   = '0;
               pend_n  = 1'b0;
               state_n = IDLE;
            end
         end
         EMIT_NUM: begin
            state_n = pend ? EMIT_OP : IDLE;
            pend_n  = 1'b0;
         end
         EMIT_OP: begin
            cnt_n   = '0;
            state_n = opc == 4'd15 ? WAIT_RES : GAP;
         end
         GAP: begin
            state_n = cnt == CW'(OP_GAP - 1) ? IDLE : GAP;
            cnt_n   = cnt + CW'(1);
         end
         WAIT_RES: begin
            if (bus.res_ready) begin
               res_n   = bus.res_value;
               rv_n    = 1'b1;
               state_n = IDLE;
            end else if (cnt == CW'(RES_TIMEOUT - 1)) begin
               err_n   = 1'b1;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end
   // rx_ready is gated by rst_n so it stays low for the whole reset, not just after the edge
   assign bus.rx_ready     = rst_n && (state == IDLE || state == ACC);
   assign bus.num_en       = state == EMIT_NUM;
   assign bus.num          = acc;
   assign bus.op_en        = state == EMIT_OP;
   assign bus.op           = opc;
   assign bus.result_valid = rv_q;
   assign bus.result       = res_q;
   assign bus.err          = err_q;
endmodule

// File: tb/tb_rpn_sequencer.sv
// tb_rpn_sequencer: table vectors, latency/timeout/reset sequences and a random byte
// stream checked against a token-level RPN model; includes a small RPN core model.
module tb_rpn_sequencer;
   localparam int OP_GAP = 4;
   localparam int RES_TIMEOUT = 16;
   typedef struct {int k; int v; int t;} ev_t;
   typedef struct {string s; int n; logic [0:5][19:0] ev;} vec_t;
   logic clk, rst_n;
   rpn_sequencer_if bus ();
   rpn_sequencer #(.OP_GAP(OP_GAP), .RES_TIMEOUT(RES_TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int cyc, total, passed, excl_viol, res_cnt, resp_delay;
   bit resp_en, spur_req;
   bit rdy_hist[int];
   ev_t obs_q[$], exp_q[$];
   int cs[$];
   logic [7:0] bq[$];
   vec_t tbl[8];
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   initial forever begin
      @(posedge clk);
      cyc++;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end
   function automatic void chk(string name, int got, int want);
      total++;
      if (got == want) passed++;
      else $display("FAIL %s: got %0d required %0d", name, got, want);
   endfunction
   function automatic int calc(int a, int b, int op);
      case (op)
         0: return (a + b) & 16'hFFFF;
         1: return (a - b) & 16'hFFFF;
         2: return (a * b) & 16'hFFFF;
         default: return b == 0 ? 16'hFFFF : a / b;
      endcase
   endfunction
   function automatic logic [19:0] ev(int k, int v);
      return {4'(k), 16'(v)};
   endfunction
   // core model: stack of pushed operands; answers '=' with the top after resp_delay cycles
   initial begin
      bus.res_ready = 0;
      bus.res_value = 0;
      forever begin
         @(negedge clk);
         rdy_hist[cyc] = bus.rx_ready;
         bus.res_ready = 0;
         if (spur_req) begin
            bus.res_ready = 1;
            bus.res_value = 16'h1234;
            spur_req = 0;
         end else if (res_cnt > 0) begin
            res_cnt--;
            if (res_cnt == 0) begin
               bus.res_ready = 1;
               bus.res_value = 16'(cs.size() > 0 ? cs[$] : 0);
            end
         end
         if (bus.num_en && bus.op_en) excl_viol++;
         if (bus.num_en) begin
            obs_q.push_back('{1, int'(bus.num), cyc});
            cs.push_back(int'(bus.num));
         end
         if (bus.op_en) begin
            obs_q.push_back('{2, int'(bus.op), cyc});
            if (bus.op == 4'd15) begin
               if (resp_en) res_cnt = resp_delay;
            end else if (bus.op < 4'd4) begin
               int b, a;
               b = cs.size() > 0 ? cs.pop_back() : 0;
               a = cs.size() > 0 ? cs.pop_back() : 0;
               cs.push_back(calc(a, b, int'(bus.op)));
            end
         end
         if (bus.result_valid) obs_q.push_back('{3, int'(bus.result), cyc});
         if (bus.err) obs_q.push_back('{4, 0, cyc});
      end
   end
   // reference: tokenise the byte stream and evaluate it as RPN
   function automatic void model(input logic [7:0] b[$]);
      int acc = 0;
      bit innum = 0;
      int st[$];
      exp_q.delete();
      foreach (b[i]) begin
         logic [7:0] c = b[i];
         int code = c == "+" ? 0 : c == "-" ? 1 : c == "*" ? 2 : c == "/" ? 3 : c == "=" ? 15 : -1;
         if (c >= "0" && c <= "9") begin
            acc = innum ? (acc * 10 + int'(c - 8'h30)) % 65536 : int'(c - 8'h30);
            innum = 1;
         end else if (c == " " || c == 8'h0D || c == 8'h0A || code >= 0) begin
            if (innum) begin
               exp_q.push_back('{1, acc, 0});
               st.push_back(acc);
            end
            innum = 0;
            if (code >= 0) begin
               exp_q.push_back('{2, code, 0});
               if (code == 15) exp_q.push_back('{3, st.size() > 0 ? st[$] : 0, 0});
               else begin
                  int y, x;
                  y = st.size() > 0 ? st.pop_back() : 0;
                  x = st.size() > 0 ? st.pop_back() : 0;
                  st.push_back(calc(x, y, code));
               end
            end
         end else begin
            exp_q.push_back('{4, 0, 0});
            innum = 0;
         end
      end
   endfunction
   task automatic send(input logic [7:0] b, output int t);
      int n = 0;
      @(negedge clk);
      bus.rx_valid = 1;
      bus.rx_data = b;
      while (!bus.rx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         chk("send accept", 0, 1);
         bus.rx_valid = 0;
         t = -1;
      end else begin
         @(posedge clk);
         #1 bus.rx_valid = 0;
         t = cyc;
      end
   endtask
   task automatic send_str(input string s);
      int t;
      for (int i = 0; i < s.len(); i++) send(s[i], t);
   endtask
   task automatic cmp_events(input string name);
      chk({name, " count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         chk($sformatf("%s ev%0d kind", name, i), obs_q[i].k, exp_q[i].k);
         chk($sformatf("%s ev%0d value", name, i), obs_q[i].v, exp_q[i].v);
      end
   endtask
   initial begin
      int t1, t2, t3, ones, nres;
      string ops, bad;
      tbl[0] = '{"12 3+=", 5, {ev(1, 12), ev(1, 3), ev(2, 0), ev(2, 15), ev(3, 15), 20'd0}};
      tbl[1] = '{"70000 ", 1, {ev(1, 4464), 20'd0, 20'd0, 20'd0, 20'd0, 20'd0}};
      tbl[2] = '{"5x9 ", 2, {ev(4, 0), ev(1, 9), 20'd0, 20'd0, 20'd0, 20'd0}};
      tbl[3] = '{"6 2*=", 5, {ev(1, 6), ev(1, 2), ev(2, 2), ev(2, 15), ev(3, 12), 20'd0}};
      tbl[4] = '{" \r\n", 0, {20'd0, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0}};
      tbl[5] = '{"?", 1, {ev(4, 0), 20'd0, 20'd0, 20'd0, 20'd0, 20'd0}};
      tbl[6] = '{"65535 1+=", 5, {ev(1, 65535), ev(1, 1), ev(2, 0), ev(2, 15), ev(3, 0), 20'd0}};
      tbl[7] = '{"8 2/=", 5, {ev(1, 8), ev(1, 2), ev(2, 3), ev(2, 15), ev(3, 4), 20'd0}};
      bus.rx_valid = 0;
      bus.rx_data = 0;
      resp_en = 1;
      resp_delay = 2;
      rst_n = 1;
      #2 rst_n = 0;
      repeat (2) @(negedge clk);
      chk("reset rx_ready", bus.rx_ready, 0);
      chk("reset num_en", bus.num_en, 0);
      chk("reset op_en", bus.op_en, 0);
      chk("reset result_valid", bus.result_valid, 0);
      chk("reset err", bus.err, 0);
      chk("reset num", bus.num, 0);
      chk("reset op", bus.op, 0);
      chk("reset result", bus.result, 0);
      @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      chk("release rx_ready", bus.rx_ready, 1);
      for (int i = 0; i < 8; i++) begin
         obs_q.delete();
         cs.delete();
         exp_q.delete();
         for (int j = 0; j < tbl[i].n; j++)
            exp_q.push_back('{int'(tbl[i].ev[j][19:16]), int'(tbl[i].ev[j][15:0]), 0});
         send_str(tbl[i].s);
         repeat (40) @(negedge clk);
         cmp_events($sformatf("vec%0d", i));
      end
      // abandoned print: core never answers; last captured result (4) must survive
      resp_en = 0;
      obs_q.delete();
      send("=", t1);
      repeat (RES_TIMEOUT + 8) @(negedge clk);
      chk("timeout events", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         chk("timeout op", obs_q[0].v, 15);
         chk("timeout err kind", obs_q[1].k, 4);
         chk("timeout err cycle", obs_q[1].t - obs_q[0].t, RES_TIMEOUT + 1);
      end
      chk("timeout result kept", bus.result, 4);
      resp_en = 1;
      // latency: op from ACC, then gap length on rx_ready
      obs_q.delete();
      send("7", t1);
      send("-", t1);
      repeat (12) @(negedge clk);
      chk("7- events", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         chk("7- num", obs_q[0].v, 7);
         chk("7- num_en at T+1", obs_q[0].t, t1);
         chk("7- op", obs_q[1].v, 1);
         chk("7- op_en at T+2", obs_q[1].t, t1 + 1);
         ones = 0;
         for (int k = 0; k <= OP_GAP; k++) ones += int'(rdy_hist[obs_q[1].t + k]);
         chk("gap rx_ready low", ones, 0);
         chk("gap rx_ready rise", int'(rdy_hist[obs_q[1].t + OP_GAP + 1]), 1);
      end
      // terminator from ACC and operator from IDLE, each one cycle after acceptance
      obs_q.delete();
      send("4", t2);
      send(" ", t2);
      send("+", t3);
      repeat (12) @(negedge clk);
      chk("4 + events", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         chk("term num_en at T+1", obs_q[0].t, t2);
         chk("idle op_en at T+1", obs_q[1].t, t3);
      end
      // res_ready outside WAIT_RES is ignored
      obs_q.delete();
      spur_req = 1;
      repeat (5) @(negedge clk);
      chk("spurious res_ready", obs_q.size(), 0);
      // reset while waiting for the result; the late answer must be dropped
      resp_delay = 8;
      obs_q.delete();
      send("=", t1);
      repeat (3) @(negedge clk);
      rst_n = 0;
      #1;
      chk("midreset rx_ready", bus.rx_ready, 0);
      chk("midreset op", bus.op, 0);
      chk("midreset result", bus.result, 0);
      chk("midreset num", bus.num, 0);
      @(negedge clk);
      rst_n = 1;
      #1 chk("midreset release rx_ready", bus.rx_ready, 1);
      repeat (20) @(negedge clk);
      nres = 0;
      foreach (obs_q[i]) if (obs_q[i].k != 2) nres++;
      chk("midreset no result/err", nres, 0);
      // random stream against the reference model
      ops = "+-*/";
      bad = "xa#.";
      resp_delay = $urandom_range(1, 4);
      obs_q.delete();
      cs.delete();
      bq.delete();
      for (int i = 0; i < 300; i++) begin
         int r = $urandom_range(0, 99);
         logic [7:0] c;
         if (r < 50) c = 8'h30 + 8'($urandom_range(0, 9));
         else if (r < 65) c = " ";
         else if (r < 68) c = r[0] ? 8'h0D : 8'h0A;
         else if (r < 88) c = ops[$urandom_range(0, 3)];
         else if (r < 95) c = "=";
         else c = bad[$urandom_range(0, 3)];
         bq.push_back(c);
      end
      model(bq);
      foreach (bq[i]) send(bq[i], t1);
      repeat (40) @(negedge clk);
      cmp_events("rand");
      chk("num_en/op_en exclusive", excl_viol, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/rpn_sequencer.md
RPN_SEQUENCER -- requirements
Module: rpn_sequencer

Interface
REQ-001 SHALL have parameter OP_GAP, default 4: idle cycles after each op_en pulse before the next byte is accepted (legal range 3..15).
REQ-002 SHALL have parameter RES_TIMEOUT, default 16: maximum WAIT_RES cycles before the print is abandoned.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port rx_valid, input, 1 bit: an ASCII byte is offered.
REQ-006 SHALL have port rx_data, input, 8 bits: offered ASCII byte.
REQ-007 SHALL have port rx_ready, output, 1 bit: byte accepted on any edge where rx_valid and rx_ready are both 1.
REQ-008 SHALL have port num_en, output, 1 bit: one-cycle push strobe to the RPN core.
REQ-009 SHALL have port num, output, 16 bits: operand to push.
REQ-010 SHALL have port op_en, output, 1 bit: one-cycle operator strobe to the RPN core.
REQ-011 SHALL have port op, output, 4 bits: operator code.
REQ-012 SHALL have port res_ready, input, 1 bit: core result strobe.
REQ-013 SHALL have port res_value, input, 16 bits: core result.
REQ-014 SHALL have port result_valid, output, 1 bit: one-cycle pulse when a result is captured.
REQ-015 SHALL have port result, output, 16 bits: captured result.
REQ-016 SHALL have port err, output, 1 bit: one-cycle pulse on a bad byte or a timeout.

Function
REQ-017 SHALL implement states IDLE, ACC, EMIT_NUM, EMIT_OP, GAP, WAIT_RES.
REQ-018 SHALL drive rx_ready=1 only in IDLE and ACC.
REQ-019 SHALL, on an accepted digit '0'-'9', set acc=digit from IDLE or acc=acc*10+digit from ACC, truncated mod 2^16 (wrap, no flag), and enter or stay in ACC.
REQ-020 SHALL treat space, CR (0x0D) and LF (0x0A) as terminators: from ACC, go to EMIT_NUM; in IDLE, ignore them.
REQ-021 SHALL map operator bytes as '+'->0, '-'->1, '*'->2, '/'->3, '='->15.
REQ-022 SHALL, for an operator accepted in IDLE, go to EMIT_OP on the next cycle.
REQ-023 SHALL, for an operator accepted in ACC, latch the operator, go to EMIT_NUM, then go to EMIT_OP.
REQ-024 SHALL, in EMIT_NUM, assert num_en for exactly one cycle with num=acc, then go to EMIT_OP if an operator is latched, else to IDLE.
REQ-025 SHALL, in EMIT_OP, assert op_en for exactly one cycle with op held stable.
REQ-026 SHALL, after EMIT_OP for codes 0-3, spend OP_GAP cycles in GAP, then return to IDLE.
REQ-027 SHALL, after EMIT_OP for code 15, go to WAIT_RES.
REQ-028 SHALL, in WAIT_RES on res_ready=1, capture result<=res_value, pulse result_valid on the next cycle, and go to IDLE.
REQ-029 SHALL, after RES_TIMEOUT WAIT_RES cycles without res_ready, pulse err and go to IDLE; result is left unchanged.
REQ-030 SHALL, on any other byte, pulse err on the next cycle, discard acc and any latched operator, and go to IDLE; no num_en or op_en is issued.
REQ-031 SHALL ignore res_ready outside WAIT_RES.
REQ-032 SHALL never assert num_en and op_en in the same cycle.
REQ-033 SHALL give latencies measured from the accepting edge T: op from IDLE gives op_en in T+1; terminator from ACC gives num_en in T+1; op from ACC gives num_en in T+1 and op_en in T+2.
REQ-034 SHALL next raise rx_ready OP_GAP+1 cycles after an op_en cycle for codes 0-3.

Reset
REQ-035 SHALL, while rst_n=0, immediately force state=IDLE, acc=0, latched operator cleared, num_en=op_en=result_valid=err=0, num=0, op=0, result=0, rx_ready=0.
REQ-036 SHALL, on a mid-operation reset (any state, including WAIT_RES), drop all pending work; a later res_ready SHALL NOT produce result_valid.
REQ-037 SHALL raise rx_ready in the first cycle after rst_n deasserts.

Verification
REQ-038 SHALL cover: bytes "12 3+=" with the core model returning 15 -> num_en with num=12, then num_en with num=3, op_en op=0, op_en op=15, result_valid result=15.
REQ-039 SHALL cover: "7-" with no space -> num_en num=7 at T+1 and op_en op=1 at T+2; rx_ready low for OP_GAP+1 cycles after op_en.
REQ-040 SHALL cover: "70000 " -> num=4464 (70000 mod 65536); no err.
REQ-041 SHALL cover: "5x" -> err pulse, no num_en, acc cleared; then "9 " -> num=9.
REQ-042 SHALL cover: "=" with res_ready never asserted -> err exactly RES_TIMEOUT cycles into WAIT_RES; result unchanged.
REQ-043 SHALL cover: rst_n pulsed low during WAIT_RES, then res_ready -> no result_valid; outputs at reset values; rx_ready=1 next cycle.
